step_down_counter: RTL and testbench
====================================

# step_down_counter

Loadable 4-bit down-counter that decrements by a selectable step (3 or 1) and reports expiry. It is the counting-down counterpart of the lab step up-counter. A tracking FSM (IDLE/RUN/EXPIRED) gives a one-cycle `done` pulse on reaching zero and a `borrow` pulse when a step would go below zero. It sits beside the up-counter in the FinalsPractice counter set and serves as a countdown timer for lab sequencers.

## Interface
- `WIDTH`, default 4: counter width in bits.
- `BIG_STEP`, default 3: decrement applied when `c`=2'b00; must be less than 2^WIDTH.
- `clk`  input  1  posedge clock.
- `reset`  input  1  asynchronous, active-high reset.
- `load`  input  1  parallel load of `data_in`; highest priority after reset.
- `count_en`  input  1  count enable; ignored outside RUN.
- `c`  input  2  step control: 00 = −BIG_STEP, 01 = −1, 10 = hold (reserved), 11 = hold.
- `data_in`  input  WIDTH  parallel load value.
- `count`  output  WIDTH  current count (registered).
- `zero`  output  1  high when `count`==0 (combinational decode of `count`).
- `busy`  output  1  high in RUN (registered state decode).
- `done`  output  1  one-cycle pulse on RUN→EXPIRED (registered).
- `borrow`  output  1  one-cycle pulse when a step was clipped at zero (registered).

## Operation
- Reset: `count`=0, state IDLE, `zero`=1, `busy`=0, `done`=0, `borrow`=0.
- Priority each edge: reset > load > count step.
- `load`=1, `data_in`≠0: `count`←`data_in`, state→RUN. This applies from any state, including mid-count.
- `load`=1, `data_in`=0: `count`←0, state→IDLE, no `done`.
- IDLE: holds `count`; `count_en` ignored.
- RUN with `count_en`=1, step s = BIG_STEP (c=00) or 1 (c=01):
  - `count` > s: `count`←`count`−s, stay RUN.
  - `count` = s: `count`←0, `done` pulse, →EXPIRED.
  - `count` < s: `count`←0 (saturate, never wrap), `done` and `borrow` pulse together, →EXPIRED.
- RUN with c=10 or 11, or with `count_en`=0: hold `count` and state.
- EXPIRED: `count` holds 0; `count_en` ignored. Only `load` or `reset` leaves EXPIRED.
- `done` and `borrow` are high for exactly one cycle, then self-clear.
- Arithmetic is in WIDTH bits. Compare before subtracting so there is no underflow wrap.
- The FSM encoding is 2 bits; the unused code recovers to IDLE with `count`←0.

## Timing
- All state changes occur on the posedge of `clk`. `count`, `busy`, `done` and `borrow` update in the same edge as the causing step (one-cycle latency from inputs).
- `zero` follows `count` combinationally, with no extra cycle.
- Reset assertion clears outputs immediately, without waiting for a clock. Reset deassertion is synchronous to the next edge. Reset mid-count discards the pending step.
- `load` asserted in the same cycle as a terminal step: load wins, and no `done` or `borrow` pulse occurs.
- Back-to-back loads each take effect on their own edge.

## Structure
- Shared package `step_counter_pkg`:
  - step-control constants `C_BIG`=2'b00, `C_ONE`=2'b01, `C_HOLD`=2'b11;
  - state constants `ST_IDLE`, `ST_RUN`, `ST_EXPIRED`;
  - default `BIG_STEP`=3.
- The package is shared with the up-counter so the `c` encodings stay aligned.
- Optional sub-module `step_decrement`: purely combinational. It takes `count` and step and returns next count, terminal flag and borrow flag. The FSM and registers stay in the top module.

## Test plan
- Reset asserted asynchronously mid-cycle → `count`=0, `zero`=1, `busy`=0 immediately. After release, `count_en`=1 with c=00 → `count` stays 0 (IDLE).
- Load 13, c=00, `count_en`=1 → `count` goes 10, 7, 4, 1. Next edge → 0 with `done`=1, `borrow`=1, →EXPIRED. Further enables → `count` stays 0, no pulses.
- Load 6, c=00 twice → 3, then 0 with `done`=1, `borrow`=0. Load 2, c=01 twice → 1, then 0 with `done`=1.
- Load 9, then c=11 or `count_en`=0 for 3 cycles → `count` stays 9, `busy`=1. Then c=01 → 8.
- Load 5 while RUN at `count`=1 with `count_en`=1 and c=01 in the same cycle → `count`=5, no `done`. Load 0 → `count`=0, IDLE, `done`=0.
- Reset during RUN at `count`=7 → `count`=0, state IDLE, `done`/`borrow` low.

Source files
------------

// File: rtl/step_counter_pkg.sv
// step_counter_pkg
// Shared definitions for the step up/down counter pair. The up-counter and
// the down-counter both decode the two-bit step control `c` using the
// constants here, so the encodings cannot drift apart.
//   C_BIG / C_ONE / C_RSVD / C_HOLD : step-control encodings
//   state_t                         : tracking FSM states (2-bit encoding)
//   DEF_BIG_STEP                    : default large step size
package step_counter_pkg;

    localparam logic [1:0] C_BIG  = 2'b00;
    localparam logic [1:0] C_ONE  = 2'b01;
    localparam logic [1:0] C_RSVD = 2'b10;
    localparam logic [1:0] C_HOLD = 2'b11;

    // Code 2'b11 is deliberately unused; the FSM recovers from it to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_EXPIRED = 2'b10
    } state_t;

    localparam int DEF_BIG_STEP = 3;

endpackage

// File: rtl/step_down_counter_decrement.sv
// step_decrement
// Purely combinational saturating decrement. It compares before subtracting,
// so the result never wraps below zero.
// Ports:
//   count      in  WIDTH  current count
//   step       in  WIDTH  amount to subtract
//   next_count out WIDTH  count - step, or 0 when the step reaches/passes zero
//   terminal   out 1      step lands on or below zero
//   borrow     out 1      step would have gone below zero (clipped)
module step_decrement #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] next_count,
    output logic             terminal,
    output logic             borrow
);

    always_comb begin
        terminal   = (count <= step);
        borrow     = (count < step);
        next_count = terminal ? '0 : (count - step);
    end

endmodule

// File: rtl/step_down_counter.sv
// step_down_counter
// Loadable down-counter with a selectable step (BIG_STEP or 1) and a tracking
// FSM (IDLE / RUN / EXPIRED). Reaching zero produces a one-cycle `done`
// pulse; a step that would pass zero saturates at 0 and also pulses `borrow`.
// Ports:
//   clk       in  1      posedge clock
//   reset     in  1      asynchronous active-high reset
//   load      in  1      parallel load of data_in (beats any count step)
//   count_en  in  1      count enable, only honoured in RUN
//   c         in  2      step control: 00 = -BIG_STEP, 01 = -1, 1x = hold
//   data_in   in  WIDTH  load value (0 loads into IDLE, non-zero into RUN)
//   count     out WIDTH  registered count
//   zero      out 1      count == 0 (combinational)
//   busy      out 1      FSM is in RUN
//   done      out 1      one-cycle pulse on RUN -> EXPIRED
//   borrow    out 1      one-cycle pulse when the terminal step was clipped
module step_down_counter
    import step_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int BIG_STEP = DEF_BIG_STEP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             count_en,
    input  logic [1:0]       c,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             borrow
);

    localparam logic [WIDTH-1:0] BIG_STEP_W = WIDTH'(BIG_STEP);
    localparam logic [WIDTH-1:0] ONE_STEP_W = WIDTH'(1);

    state_t           state;
    logic [WIDTH-1:0] step;
    logic             step_valid;
    logic [WIDTH-1:0] dec_count;
    logic             dec_terminal;
    logic             dec_borrow;

    // Only C_BIG and C_ONE move the counter; the reserved and hold codes
    // leave it where it is.
    always_comb begin
        step       = ONE_STEP_W;
        step_valid = 1'b0;
        case (c)
            C_BIG: begin
                step       = BIG_STEP_W;
                step_valid = count_en;
            end
            C_ONE: begin
                step       = ONE_STEP_W;
                step_valid = count_en;
            end
            default: begin
                step       = ONE_STEP_W;
                step_valid = 1'b0;
            end
        endcase
    end

    step_decrement #(
        .WIDTH(WIDTH)
    ) u_decrement (
        .count      (count),
        .step       (step),
        .next_count (dec_count),
        .terminal   (dec_terminal),
        .borrow     (dec_borrow)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            state  <= ST_IDLE;
            done   <= 1'b0;
            borrow <= 1'b0;
        end else begin
            // Pulses self-clear unless a terminal step re-asserts them below.
            done   <= 1'b0;
            borrow <= 1'b0;
            if (load) begin
                // Load overrides any step in the same cycle, so a terminal
                // step coinciding with a load never pulses done/borrow.
                count <= data_in;
                state <= (data_in != '0) ? ST_RUN : ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        count <= count;
                    end
                    ST_RUN: begin
                        if (step_valid) begin
                            count <= dec_count;
                            if (dec_terminal) begin
                                state  <= ST_EXPIRED;
                                done   <= 1'b1;
                                borrow <= dec_borrow;
                            end
                        end
                    end
                    ST_EXPIRED: begin
                        count <= '0;
                    end
                    default: begin
                        // Unused encoding: return to a known idle state.
                        count <= '0;
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy = (state == ST_RUN);
    assign zero = (count == '0);

endmodule

// File: tb/tb_step_down_counter.sv
module tb_step_down_counter;

    localparam int WIDTH = 4;

    logic             clk;
    logic             reset;
    logic             load;
    logic             count_en;
    logic [1:0]       c;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] count;
    logic             zero;
    logic             busy;
    logic             done;
    logic             borrow;

    step_down_counter #(
        .WIDTH    (WIDTH),
        .BIG_STEP (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .count_en (count_en),
        .c        (c),
        .data_in  (data_in),
        .count    (count),
        .zero     (zero),
        .busy     (busy),
        .done     (done),
        .borrow   (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        int z;
        int b;
        int d;
        int br;
        string tag;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    // Reference model state: 0 = idle, 1 = run, 2 = expired
    int m_count = 0;
    int m_state = 0;

    task automatic check(input string tag, input int obs, input int exp_v);
        checks++;
        if (obs != exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge, predict the result of
    // the next rising edge and queue it for the monitor.
    task automatic drive(input string tag, input bit ld, input int d,
                         input bit en, input logic [1:0] cc);
        exp_t e;
        int   s;
        int   pd = 0;
        int   pb = 0;
        load     = ld;
        data_in  = WIDTH'(d);
        count_en = en;
        c        = cc;
        if (ld) begin
            m_count = d;
            m_state = (d != 0) ? 1 : 0;
        end else if (m_state == 1 && en && (cc == 2'b00 || cc == 2'b01)) begin
            s = (cc == 2'b00) ? 3 : 1;
            if (m_count > s) begin
                m_count = m_count - s;
            end else begin
                pd      = 1;
                pb      = (m_count < s) ? 1 : 0;
                m_count = 0;
                m_state = 2;
            end
        end
        e.cnt = m_count;
        e.z   = (m_count == 0) ? 1 : 0;
        e.b   = (m_state == 1) ? 1 : 0;
        e.d   = pd;
        e.br  = pb;
        e.tag = tag;
        sb.push_back(e);
        @(negedge clk);
    endtask

    // Asynchronous reset placed between clock edges; outputs must clear at
    // once, before any rising edge.
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        check({tag, "_count"},  int'(count),  0);
        check({tag, "_zero"},   int'(zero),   1);
        check({tag, "_busy"},   int'(busy),   0);
        check({tag, "_done"},   int'(done),   0);
        check({tag, "_borrow"}, int'(borrow), 0);
        m_count = 0;
        m_state = 0;
        load     = 1'b0;
        count_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: compare outputs shortly after each rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, "_count"},  int'(count),  e.cnt);
            check({e.tag, "_zero"},   int'(zero),   e.z);
            check({e.tag, "_busy"},   int'(busy),   e.b);
            check({e.tag, "_done"},   int'(done),   e.d);
            check({e.tag, "_borrow"}, int'(borrow), e.br);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b1;
        load     = 1'b0;
        count_en = 1'b0;
        c        = 2'b00;
        data_in  = '0;
        repeat (2) @(negedge clk);
        check("rst_count",  int'(count),  0);
        check("rst_zero",   int'(zero),   1);
        check("rst_busy",   int'(busy),   0);
        check("rst_done",   int'(done),   0);
        check("rst_borrow", int'(borrow), 0);
        reset = 1'b0;

        // Mid-cycle asynchronous reset, then enables in IDLE do nothing.
        drive("pre_load", 1, 9, 0, 2'b00);
        async_reset("arst");
        drive("idle_en0", 0, 0, 1, 2'b00);
        drive("idle_en1", 0, 0, 1, 2'b00);

        // 13 by threes: 10 7 4 1, then clipped to 0 with done+borrow.
        drive("ld13", 1, 13, 0, 2'b00);
        for (int i = 0; i < 5; i++) drive("big", 0, 0, 1, 2'b00);
        drive("exp_hold0", 0, 0, 1, 2'b00);
        drive("exp_hold1", 0, 0, 1, 2'b01);

        // Exact terminal steps.
        drive("ld6", 1, 6, 0, 2'b00);
        drive("six_a", 0, 0, 1, 2'b00);
        drive("six_b", 0, 0, 1, 2'b00);
        drive("ld2", 1, 2, 0, 2'b01);
        drive("two_a", 0, 0, 1, 2'b01);
        drive("two_b", 0, 0, 1, 2'b01);

        // Hold conditions in RUN.
        drive("ld9", 1, 9, 0, 2'b00);
        drive("hold_c11", 0, 0, 1, 2'b11);
        drive("hold_en0", 0, 0, 0, 2'b00);
        drive("hold_c10", 0, 0, 1, 2'b10);
        drive("nine_one", 0, 0, 1, 2'b01);

        // Load beats a terminal step; load 0 goes to IDLE with no done.
        drive("ld2b", 1, 2, 0, 2'b01);
        drive("to_one", 0, 0, 1, 2'b01);
        drive("ld5_term", 1, 5, 1, 2'b01);
        drive("ld0", 1, 0, 1, 2'b01);
        drive("idle_after0", 0, 0, 1, 2'b01);

        // Back-to-back loads.
        drive("b2b_4", 1, 4, 1, 2'b00);
        drive("b2b_11", 1, 11, 1, 2'b00);
        drive("b2b_15", 1, 15, 1, 2'b00);
        drive("b2b_step", 0, 0, 1, 2'b00);

        // Randomised traffic.
        for (int i = 0; i < 60; i++) begin
            drive("rnd", ($urandom_range(0, 5) == 0), int'($urandom_range(0, 15)),
                  bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        end

        // Reset while running at 7.
        drive("ld13r", 1, 13, 0, 2'b00);
        drive("r_10", 0, 0, 1, 2'b00);
        drive("r_7", 0, 0, 1, 2'b00);
        async_reset("run_rst");
        drive("post_rst", 0, 0, 1, 2'b00);

        // Let the monitor drain the scoreboard, with a bound.
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        check("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
